alu_div_seq: RTL and testbench
==============================

# alu_div_seq

Multi-cycle RV32M divide/remainder sequencer for the execute stage. Runs restoring division one quotient bit per cycle on the shared `alu32` instance, using its subtract function, and owns that ALU's inputs while busy. The core's execute mux gives this block's ALU-drive ports priority whenever `busy` is high. Issue uses a valid/ready handshake from decode, and the result uses a valid/ready handshake to writeback.

## Interface
- `XLEN`, default 32: operand and result width. Only 32 is supported.
- `CNT_W`, default 5: iteration-counter width, equal to log2(`XLEN`).

Ports (name, direction, width, meaning):
- `clk`  in  1  sole clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  a divide request is presented.
- `in_ready`  out  1  the block can accept a request. High only in IDLE.
- `in_op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `in_a`  in  32  dividend.
- `in_b`  in  32  divisor.
- `out_valid`  out  1  `out_result` is valid.
- `out_ready`  in  1  writeback accepts the result.
- `out_result`  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- `busy`  out  1  high in every state except IDLE.
- `alu_x`  out  32  ALU operand X.
- `alu_y`  out  32  ALU operand Y.
- `alu_select`  out  4  ALU function select. Only 4'b1000 (subtract) and 4'b0000 are driven.
- `alu_result`  in  32  ALU result, combinational, same cycle.

## Operation
- States: IDLE, NEG_A, NEG_B, ITER, FIX, DONE.
- **IDLE**
  - On `in_valid && in_ready`, latch op, A, B, `sign_q = A[31]^B[31]` and `sign_r = A[31]`. Both sign flags are zero for DIVU/REMU.
  - Latch the special-case flags: `div0 = (B==0)`, and `ovf = signed && A==32'h8000_0000 && B==32'hFFFF_FFFF`.
  - Go to NEG_A.
- **NEG_A**: drive ALU with `0 - A`, select 4'b1000. The quotient/shift register `q` takes `alu_result` if signed and A[31], otherwise A. Go to NEG_B.
- **NEG_B**: same operation on B, into register `d`. Clear `rem`, `rem_hi` and `cnt`. Go to ITER.
- **ITER**, 32 cycles:
  - Form `s = {rem, q[31]}`, 33 bits.
  - Drive `alu_x = s[31:0]`, `alu_y = d`, select 4'b1000.
  - `borrow = (~s[31] & d[31]) | (~(s[31]^d[31]) & alu_result[31])`.
  - `take = s[32] | ~borrow`.
  - `rem <= take ? alu_result : s[31:0]`.
  - `q <= {q[30:0], take}`.
  - `cnt` increments. When `cnt==31`, go to FIX.
- **FIX**:
  - Select `v = q` for DIV/DIVU, or `v = rem` for REM/REMU.
  - If the matching sign flag is set and `v != 0`, drive `0 - v` through the ALU and register the ALU result. Otherwise register `v`.
  - Special-case override: `div0` gives quotient 32'hFFFF_FFFF and remainder = original A. `ovf` gives quotient 32'h8000_0000 and remainder 0.
  - Go to DONE.
- **DONE**: `out_valid=1` and `out_result` is held stable. On `out_ready`, go to IDLE. `in_ready` stays 0 during DONE, so no accept happens on the same cycle as the output handshake.
- In IDLE and DONE: `alu_x=0`, `alu_y=0`, `alu_select=4'b0000`.
- Keep an original-A register for the `div0` remainder.

## Timing
- Reset, from any state including mid-ITER: state IDLE, all datapath registers cleared, the in-flight request is discarded.
- Output values after reset: `out_valid=0`, `in_ready=1`, `busy=0`, `out_result=0`, ALU outputs zero.
- Accept on cycle T. `out_valid` rises at T+36: NEG_A T+1, NEG_B T+2, ITER T+3..T+34, FIX T+35.
- Latency is fixed regardless of operands, unless the configuration option below is compiled in.
- Throughput: one operation per 37 cycles at best, because DONE→IDLE costs one cycle.
- `in_a`, `in_b` and `in_op` are sampled only on the accept cycle.

## Configuration
- `ALU_DIV_EARLY_OUT_EN` defined:
  - When `div0` or `ovf` is detected at accept, go from IDLE straight to DONE. `out_valid` rises at T+1 with the special-case value.
  - The ALU is not driven for that operation.
- Not defined: special cases take the full 36-cycle path and are overridden in FIX. Results are identical either way.

## Structure
- Shared package `klp32_div_pkg` holds:
  - the state enum;
  - the `in_op` encodings;
  - ALU select constants `ALU_SUB=4'b1000` and `ALU_ADD=4'b0000`;
  - `DIV_OVF_A=32'h8000_0000`.
- One sub-module, `div_special_detect`: combinational. Inputs A, B and signed; outputs `div0` and `ovf`.

## Test plan
- DIVU A=100, B=7 → `out_result=14` at T+36. REMU with the same operands → 2.
- REM A=-7 (32'hFFFF_FFF9), B=2 → 32'hFFFF_FFFF. DIV with the same operands → 32'hFFFF_FFFD.
- DIV A=32'h8000_0000, B=32'hFFFF_FFFF → 32'h8000_0000. REM with the same operands → 0.
  - With the macro defined, `out_valid` at T+1; otherwise at T+36.
- DIVU A=1234, B=0 → 32'hFFFF_FFFF. REM A=-5, B=0 → 32'hFFFF_FFFB.
- Hold `out_ready=0` for 5 cycles after `out_valid` rises. `out_result` must stay stable and `in_ready` must stay 0. Accept on the 6th cycle; `in_ready=1` on the next cycle.
- Assert `reset` on the 10th ITER cycle. Next cycle: IDLE, `busy=0`. A fresh DIVU 9/3 then returns 3 at T+36.

Source files
------------

// File: rtl/klp32_div_pkg.sv
// Shared definitions for the RV32M divide sequencer: FSM states, op codes,
// ALU select values and the signed-overflow dividend constant.
// Pure declarations; no logic, no latency, no backpressure.
package klp32_div_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NEG_A,
        ST_NEG_B,
        ST_ITER,
        ST_FIX,
        ST_DONE
    } div_state_t;

    // funct3[1:0] encodings
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    localparam logic [3:0] ALU_SUB = 4'b1000;
    localparam logic [3:0] ALU_ADD = 4'b0000;

    localparam logic [31:0] DIV_OVF_A = 32'h8000_0000;

    // Bit 0 of the op distinguishes unsigned (1) from signed (0)
    function automatic logic op_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

    // Bit 1 of the op selects remainder (1) over quotient (0)
    function automatic logic op_is_rem(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/div_special_detect.sv
// Flags divide-by-zero and signed overflow (INT_MIN / -1) on raw operands.
// Purely combinational, zero latency.
// No handshake; the caller samples the flags on its accept cycle.
module div_special_detect
    import klp32_div_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    output logic            div0,
    output logic            ovf
);

    assign div0 = (b == '0);
    assign ovf  = is_signed && (a == DIV_OVF_A) && (b == '1);

endmodule

// File: rtl/alu_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring division on the shared ALU, one bit per cycle.
// Latency: accept at T, out_valid at T+36 (T+1 for div0/ovf when ALU_DIV_EARLY_OUT_EN is defined).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, one idle cycle before next accept.
module alu_div_seq
    import klp32_div_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy,
    output logic [XLEN-1:0] alu_x,
    output logic [XLEN-1:0] alu_y,
    output logic [3:0]      alu_select,
    input  logic [XLEN-1:0] alu_result
);

    div_state_t        state;
    logic [1:0]        op_q;
    logic [XLEN-1:0]   a_q;        // original dividend, also the div0 remainder
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   q;          // dividend magnitude shifting out, quotient shifting in
    logic [XLEN-1:0]   d;          // divisor magnitude
    logic [XLEN-1:0]   rem;
    logic [CNT_W-1:0]  cnt;
    logic              sign_q;
    logic              sign_r;
    logic              div0_q;
    logic              ovf_q;

    logic              in_signed;
    logic              det_div0;
    logic              det_ovf;
    logic              accept;
    logic [XLEN:0]     s;
    logic              borrow;
    logic              take;
    logic [XLEN-1:0]   v;
    logic              fix_neg;

    // Result for a special case, in the RISC-V defined form
    function automatic logic [XLEN-1:0] special_result(input logic [1:0] op,
                                                       input logic [XLEN-1:0] a,
                                                       input logic is_div0);
        if (is_div0)
            return op_is_rem(op) ? a : '1;
        return op_is_rem(op) ? '0 : DIV_OVF_A;
    endfunction

    assign in_signed = op_is_signed(in_op);
    assign accept    = in_valid && in_ready;

    div_special_detect #(.XLEN(XLEN)) u_detect (
        .a         (in_a),
        .b         (in_b),
        .is_signed (in_signed),
        .div0      (det_div0),
        .ovf       (det_ovf)
    );

    // Trial subtraction: s[31:0] - d via the ALU; borrow recovered from sign bits
    assign s       = {rem, q[XLEN-1]};
    assign borrow  = (~s[XLEN-1] & d[XLEN-1]) | (~(s[XLEN-1] ^ d[XLEN-1]) & alu_result[XLEN-1]);
    assign take    = s[XLEN] | ~borrow;

    // Final value and whether it needs a sign flip
    assign v       = op_is_rem(op_q) ? rem : q;
    assign fix_neg = (op_is_rem(op_q) ? sign_r : sign_q) && (v != '0);

    // ALU operand drive, combinational so the result is usable in the same cycle
    always_comb begin
        alu_x      = '0;
        alu_y      = '0;
        alu_select = ALU_ADD;
        case (state)
            ST_NEG_A: begin
                alu_y      = a_q;
                alu_select = ALU_SUB;
            end
            ST_NEG_B: begin
                alu_y      = b_q;
                alu_select = ALU_SUB;
            end
            ST_ITER: begin
                alu_x      = s[XLEN-1:0];
                alu_y      = d;
                alu_select = ALU_SUB;
            end
            ST_FIX: begin
                if (fix_neg && !(div0_q || ovf_q)) begin
                    alu_y      = v;
                    alu_select = ALU_SUB;
                end
            end
            default: begin
            end
        endcase
    end

    // Sequencer FSM with datapath registers and registered handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            q          <= '0;
            d          <= '0;
            rem        <= '0;
            cnt        <= '0;
            sign_q     <= 1'b0;
            sign_r     <= 1'b0;
            div0_q     <= 1'b0;
            ovf_q      <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_result <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q     <= in_op;
                        a_q      <= in_a;
                        b_q      <= in_b;
                        sign_q   <= in_signed & (in_a[XLEN-1] ^ in_b[XLEN-1]);
                        sign_r   <= in_signed & in_a[XLEN-1];
                        div0_q   <= det_div0;
                        ovf_q    <= det_ovf;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
`ifdef ALU_DIV_EARLY_OUT_EN
                        if (det_div0 || det_ovf) begin
                            out_result <= special_result(in_op, in_a, det_div0);
                            out_valid  <= 1'b1;
                            state      <= ST_DONE;
                        end else begin
                            state <= ST_NEG_A;
                        end
`else
                        state <= ST_NEG_A;
`endif
                    end
                end
                ST_NEG_A: begin
                    q     <= (op_is_signed(op_q) && a_q[XLEN-1]) ? alu_result : a_q;
                    state <= ST_NEG_B;
                end
                ST_NEG_B: begin
                    d     <= (op_is_signed(op_q) && b_q[XLEN-1]) ? alu_result : b_q;
                    rem   <= '0;
                    cnt   <= '0;
                    state <= ST_ITER;
                end
                ST_ITER: begin
                    rem <= take ? alu_result : s[XLEN-1:0];
                    q   <= {q[XLEN-2:0], take};
                    cnt <= cnt + 1'b1;
                    if (cnt == '1)
                        state <= ST_FIX;
                end
                ST_FIX: begin
                    if (div0_q || ovf_q)
                        out_result <= special_result(op_q, a_q, div0_q);
                    else if (fix_neg)
                        out_result <= alu_result;
                    else
                        out_result <= v;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div_seq.sv
// Self-checking bench for alu_div_seq with an arithmetic reference model and a behavioural alu32.
module tb_alu_div_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        busy;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [3:0]  alu_select;
    logic [31:0] alu_result;

    int errors = 0;
    int checks = 0;

    alu_div_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .busy       (busy),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_select (alu_select),
        .alu_result (alu_result)
    );

    // Shared ALU: subtract on 4'b1000, add otherwise
    assign alu_result = (alu_select == 4'b1000) ? (alu_x - alu_y) : (alu_x + alu_y);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V M-extension semantics from plain integer arithmetic
    function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        logic ovf;
        sa = a;
        sb = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            2'b00: ref_div = (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            2'b01: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b10: ref_div = (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
            default: ref_div = (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef ALU_DIV_EARLY_OUT_EN
        if (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
            return 1;
`endif
        return 36;
    endfunction

    // Issue one request from IDLE and wait (bounded) for out_valid; inputs are scrambled after accept
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
    endtask

    // Complete the output handshake
    task automatic drain;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 7;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (out_result !== 32'h0) begin errors++; $display("FAIL reset_out_result got=%h want=0", out_result); end
        if (alu_x !== 32'h0) begin errors++; $display("FAIL reset_alu_x got=%h want=0", alu_x); end
        if (alu_y !== 32'h0) begin errors++; $display("FAIL reset_alu_y got=%h want=0", alu_y); end
        if (alu_select !== 4'b0000) begin errors++; $display("FAIL reset_alu_select got=%b want=0000", alu_select); end
    endtask

    task automatic test_directed;
        logic [1:0]  ops [8] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b10, 2'b01, 2'b10};
        logic [31:0] as  [8] = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                 32'h8000_0000, 32'h8000_0000, 32'd1234, 32'hFFFF_FFFB};
        logic [31:0] bs  [8] = '{32'd7, 32'd7, 32'd2, 32'd2,
                                 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
        logic [31:0] exp [8] = '{32'd14, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
                                 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
        logic [31:0] res;
        int lat;
        for (int i = 0; i < 8; i++) begin
            do_op(ops[i], as[i], bs[i], res, lat);
            checks += 2;
            if (res !== exp[i]) begin
                errors++;
                $display("FAIL directed_result[%0d] got=%h want=%h", i, res, exp[i]);
            end
            if (lat != ref_lat(ops[i], as[i], bs[i])) begin
                errors++;
                $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, ref_lat(ops[i], as[i], bs[i]));
            end
            drain();
        end
    endtask

    task automatic test_alu_drive;
        logic [31:0] res;
        int lat;
        in_valid = 1'b1;
        in_op    = 2'b00;
        in_a     = 32'd100;
        in_b     = 32'hFFFF_FFF9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks += 5;
        if (busy !== 1'b1) begin errors++; $display("FAIL neg_a_busy got=%b want=1", busy); end
        if (in_ready !== 1'b0) begin errors++; $display("FAIL neg_a_in_ready got=%b want=0", in_ready); end
        if (alu_select !== 4'b1000) begin errors++; $display("FAIL neg_a_select got=%b want=1000", alu_select); end
        if (alu_x !== 32'h0) begin errors++; $display("FAIL neg_a_alu_x got=%h want=0", alu_x); end
        if (alu_y !== 32'd100) begin errors++; $display("FAIL neg_a_alu_y got=%h want=64", alu_y); end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_result;
        checks += 2;
        if (res !== ref_div(2'b00, 32'd100, 32'hFFFF_FFF9)) begin
            errors++; $display("FAIL neg_div_result got=%h want=%h", res, ref_div(2'b00, 32'd100, 32'hFFFF_FFF9));
        end
        if (alu_select !== 4'b0000) begin errors++; $display("FAIL done_alu_select got=%b want=0000", alu_select); end
        drain();
    endtask

    task automatic test_backpressure;
        logic [31:0] res;
        int lat;
        do_op(2'b01, 32'd77, 32'd5, res, lat);
        checks += 1;
        if (res !== 32'd15) begin errors++; $display("FAIL bp_result got=%h want=%h", res, 32'd15); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks += 3;
            if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b want=1", i, out_valid); end
            if (out_result !== res) begin errors++; $display("FAIL bp_stable[%0d] got=%h want=%h", i, out_result, res); end
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b want=0", i, in_ready); end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checks += 3;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy got=%b want=0", busy); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] res;
        int lat;
        in_valid = 1'b1;
        in_op    = 2'b01;
        in_a     = 32'hDEAD_BEEF;
        in_b     = 32'd13;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // now in T+1; advance to the 10th ITER cycle, T+12
        repeat (11) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got=%b want=0", busy); end
        if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid got=%b want=0", out_valid); end
        if (alu_select !== 4'b0000) begin errors++; $display("FAIL midreset_alu_select got=%b want=0000", alu_select); end
        do_op(2'b01, 32'd9, 32'd3, res, lat);
        checks += 2;
        if (res !== 32'd3) begin errors++; $display("FAIL midreset_div_result got=%h want=3", res); end
        if (lat != 36) begin errors++; $display("FAIL midreset_div_latency got=%0d want=36", lat); end
        drain();
    endtask

    task automatic test_random;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int lat;
        int kind;
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            a    = $urandom;
            b    = $urandom;
            kind = $urandom_range(0, 9);
            if (kind == 0) b = 32'h0;
            else if (kind == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (kind == 2) begin a = 32'($urandom_range(0, 300)); b = 32'($urandom_range(1, 20)); end
            else if (kind == 3) b = 32'($signed(-$urandom_range(1, 20)));
            do_op(op, a, b, res, lat);
            checks += 2;
            if (res !== ref_div(op, a, b)) begin
                errors++;
                $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h want=%h", i, op, a, b, res, ref_div(op, a, b));
            end
            if (lat != ref_lat(op, a, b)) begin
                errors++;
                $display("FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, ref_lat(op, a, b));
            end
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            drain();
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = 32'h0;
        in_b      = 32'h0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_alu_drive();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
